axis_cmd_engine: RTL
====================

Name: axis_cmd_engine

Overview:
- Register-programmable, multi-channel command/status engine for the AXI DataMover.
- Generalises the single-channel stream command master to NUM_CHANNELS channels, each with:
  - its own command FIFO and auto-incrementing tag;
  - its own status FIFO;
  - a maskable per-channel interrupt.
- Sits between the axi4_lite_slave set/get bus (after page decode) and the DataMover MM2S/S2MM command and status ports.
- irq is the OR of all enabled channel interrupts.

Parameters:
- NUM_CHANNELS, 2, number of independent command/status channels (1..8).
- C_S_AXI_ADDR_WIDTH, 32, set/get address width.
- C_S_AXI_DATA_WIDTH, 32, set/get data width (only 32 supported).
- CMD_DEPTH, 4, command FIFO entries per channel (power of two, 2..16).
- STS_DEPTH, 4, status FIFO entries per channel (power of two, 2..16).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- set_addr  in  C_S_AXI_ADDR_WIDTH  write address (byte).
- set_data  in  C_S_AXI_DATA_WIDTH  write data.
- set_stb  in  1  one-cycle write strobe.
- get_addr  in  C_S_AXI_ADDR_WIDTH  read address (byte).
- get_data  out  C_S_AXI_DATA_WIDTH  read data, combinational from get_addr.
- get_stb  in  1  one-cycle read strobe; side effects only.
- M_AXIS_CMD_TVALID  out  NUM_CHANNELS  per-channel command valid.
- M_AXIS_CMD_TREADY  in  NUM_CHANNELS  per-channel command ready.
- M_AXIS_CMD_TDATA  out  72*NUM_CHANNELS  channel c occupies bits [72c+71:72c].
- S_AXIS_STS_TVALID  in  NUM_CHANNELS  per-channel status valid.
- S_AXIS_STS_TREADY  out  NUM_CHANNELS  per-channel status ready.
- S_AXIS_STS_TDATA  in  8*NUM_CHANNELS  channel c occupies bits [8c+7:8c].
- irq_vec  out  NUM_CHANNELS  per-channel interrupt.
- irq  out  1  OR of irq_vec.

Behaviour:
- Decode:
  - reg = addr[4:2];
  - ch = addr[5+CHW-1:5], where CHW = max(1, clog2(NUM_CHANNELS));
  - higher address bits are ignored;
  - ch >= NUM_CHANNELS: writes ignored, reads return 0.
- Registers per channel:
  - 0x00 ADDR (R/W): shadow start address.
  - 0x04 LEN (W): pushes a command; read returns 0.
  - 0x08 STS (R): {valid[31], 23'b0, sts[7:0]}, showing the status FIFO head.
  - 0x0C CNT (R/W1C):
    - [7:0] cmd occupancy;
    - [15:8] sts occupancy;
    - [19:16] next tag;
    - [30] zero-BTT sticky;
    - [31] overflow sticky.
  - 0x10 MASK (R/W): bit0 is the interrupt enable.
  - Other offsets: read 0, write ignored.
- LEN write:
  - Field mapping: BTT = set_data[22:0], EOF = set_data[30].
  - BTT == 0: no push; set zero-BTT sticky.
  - Command FIFO full: no push, unless the same channel pops that cycle, in which case the push is accepted. A dropped push sets the overflow sticky.
  - Pushed word:
    - [71:68] = 0;
    - [67:64] = tag;
    - [63:32] = ADDR;
    - [31] DRR = 0;
    - [30] = EOF;
    - [29:24] DSA = 0;
    - [23] type = 1 (INCR);
    - [22:0] = BTT.
  - Tag increments by 1 mod 16 on accepted pushes only.
- Command output:
  - TVALID = FIFO non-empty; TDATA = FIFO head.
  - Pop on TVALID & TREADY.
  - TDATA is stable while TVALID and !TREADY.
  - First-word fall-through: a push into an empty FIFO makes TVALID high the next cycle.
- Status input:
  - TREADY = !sts_full & !rst.
  - Push on TVALID & TREADY.
- Status read:
  - get_stb to STS with a non-empty FIFO pops the head.
  - Reading an empty FIFO returns 0 and does not pop.
  - A simultaneous push and pop is legal; occupancy is unchanged.
- CNT write:
  - bit31 = 1 clears overflow; bit30 = 1 clears zero-BTT.
  - A set in the same cycle wins over a clear.
- Interrupts:
  - irq_vec[c] = MASK[c] & sts_nonempty[c], registered (one-cycle latency).
  - irq is the registered OR of irq_vec.
- Reset:
  - FIFOs empty; tags, ADDR, MASK and stickies are 0.
  - All TVALID/TREADY, irq_vec and irq are 0.
  - A reset mid-burst discards queued commands and statuses without emitting them.
- get_data depends only on get_addr and state; set and get in the same cycle are independent.

Test Plan:
- ch0: ADDR=0x10000000, LEN=0x40000100, TREADY=1 -> one TVALID beat, TDATA=72'h0_0_10000000_40800100, tag 0; CNT[19:16]=1.
- ch1: TREADY=0, 5 LEN writes of 0x10 with CMD_DEPTH=4 -> CNT[7:0]=4, overflow=1, tags 0..3 emitted in order after TREADY=1; W1C bit31 clears overflow.
- LEN=0 on ch0 -> no TVALID, CNT[30]=1, tag unchanged.
- ch1 MASK=1, STS beat 0x80 -> irq_vec=2'b10 and irq=1 one cycle later; STS read returns 0x80000080 and pops; irq falls next cycle; re-read returns 0.
- 17 LEN writes with continuous TREADY -> tag wraps 15 -> 0; 16 STS beats with STS_DEPTH=4 and no reads -> TREADY low after 4 accepted beats.
- rst asserted with 3 commands queued and TREADY=0 -> TVALID=0, CNT=0, irq=0 the cycle after rst.

Source files
------------

// File: rtl/axis_cmd_engine.sv
// Multi-channel DataMover command/status engine: per-channel command FIFO with
// auto-incrementing tag, status FIFO, sticky error flags and maskable interrupt.
module axis_cmd_engine #(
    parameter int NUM_CHANNELS       = 2,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int CMD_DEPTH          = 4,
    parameter int STS_DEPTH          = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   set_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   set_data,
    input  logic                            set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   get_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   get_data,
    input  logic                            get_stb,
    output logic [NUM_CHANNELS-1:0]         M_AXIS_CMD_TVALID,
    input  logic [NUM_CHANNELS-1:0]         M_AXIS_CMD_TREADY,
    output logic [72*NUM_CHANNELS-1:0]      M_AXIS_CMD_TDATA,
    input  logic [NUM_CHANNELS-1:0]         S_AXIS_STS_TVALID,
    output logic [NUM_CHANNELS-1:0]         S_AXIS_STS_TREADY,
    input  logic [8*NUM_CHANNELS-1:0]       S_AXIS_STS_TDATA,
    output logic [NUM_CHANNELS-1:0]         irq_vec,
    output logic                            irq
);

    localparam int NC  = NUM_CHANNELS;
    localparam int CHW = (NC > 1) ? $clog2(NC) : 1;
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int SPW = $clog2(STS_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int SCW = SPW + 1;

    localparam logic [2:0] REG_ADDR = 3'd0;
    localparam logic [2:0] REG_LEN  = 3'd1;
    localparam logic [2:0] REG_STS  = 3'd2;
    localparam logic [2:0] REG_CNT  = 3'd3;
    localparam logic [2:0] REG_MASK = 3'd4;

    // Address decode: register in [4:2], channel in the bits just above.
    logic [2:0]     wr_reg;
    logic [2:0]     rd_reg;
    logic [CHW-1:0] wr_ch;
    logic [CHW-1:0] rd_ch;
    logic           wr_hit;
    logic           rd_hit;
    logic           btt_zero;

    assign wr_reg   = set_addr[4:2];
    assign rd_reg   = get_addr[4:2];
    assign wr_ch    = set_addr[5+CHW-1:5];
    assign rd_ch    = get_addr[5+CHW-1:5];
    assign wr_hit   = set_stb && (int'(wr_ch) < NC);
    assign rd_hit   = int'(rd_ch) < NC;
    assign btt_zero = (set_data[22:0] == 23'h0);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:5+CHW], set_addr[1:0],
                                get_addr[C_S_AXI_ADDR_WIDTH-1:5+CHW], get_addr[1:0]};

    // Architectural state
    logic [31:0]    addr_reg [NC];
    logic [3:0]     tag      [NC];
    logic [NC-1:0]  mask_reg;
    logic [NC-1:0]  ovf_flag;
    logic [NC-1:0]  zbtt_flag;

    logic [71:0]    cmd_mem  [NC][CMD_DEPTH];
    logic [CPW-1:0] cmd_wp   [NC];
    logic [CPW-1:0] cmd_rp   [NC];
    logic [CCW-1:0] cmd_cnt  [NC];

    logic [7:0]     sts_mem  [NC][STS_DEPTH];
    logic [SPW-1:0] sts_wp   [NC];
    logic [SPW-1:0] sts_rp   [NC];
    logic [SCW-1:0] sts_cnt  [NC];

    logic [NC-1:0]  irq_vec_r;
    logic           irq_r;

    // Per-channel handshake and register-strobe decode
    logic [NC-1:0]  addr_hit;
    logic [NC-1:0]  len_hit;
    logic [NC-1:0]  cnt_hit;
    logic [NC-1:0]  mask_hit;
    logic [NC-1:0]  cmd_valid;
    logic [NC-1:0]  cmd_full;
    logic [NC-1:0]  cmd_pop;
    logic [NC-1:0]  cmd_push;
    logic [NC-1:0]  ovf_set;
    logic [NC-1:0]  zbtt_set;
    logic [NC-1:0]  sts_full;
    logic [NC-1:0]  sts_nonempty;
    logic [NC-1:0]  sts_ready;
    logic [NC-1:0]  sts_push;
    logic [NC-1:0]  sts_pop;
    logic [71:0]    cmd_word [NC];
    logic [72*NC-1:0] cmd_tdata;

    always_comb begin
        addr_hit     = '0;
        len_hit      = '0;
        cnt_hit      = '0;
        mask_hit     = '0;
        cmd_valid    = '0;
        cmd_full     = '0;
        cmd_pop      = '0;
        cmd_push     = '0;
        ovf_set      = '0;
        zbtt_set     = '0;
        sts_full     = '0;
        sts_nonempty = '0;
        sts_ready    = '0;
        sts_push     = '0;
        sts_pop      = '0;
        cmd_tdata    = '0;
        for (int c = 0; c < NC; c++) begin
            addr_hit[c] = wr_hit && (int'(wr_ch) == c) && (wr_reg == REG_ADDR);
            len_hit[c]  = wr_hit && (int'(wr_ch) == c) && (wr_reg == REG_LEN);
            cnt_hit[c]  = wr_hit && (int'(wr_ch) == c) && (wr_reg == REG_CNT);
            mask_hit[c] = wr_hit && (int'(wr_ch) == c) && (wr_reg == REG_MASK);

            cmd_valid[c] = (cmd_cnt[c] != '0);
            cmd_full[c]  = (cmd_cnt[c] == CCW'(CMD_DEPTH));
            cmd_pop[c]   = cmd_valid[c] && M_AXIS_CMD_TREADY[c];
            // A full FIFO still takes the push when its head leaves in the same cycle.
            cmd_push[c]  = len_hit[c] && !btt_zero && (!cmd_full[c] || cmd_pop[c]);
            ovf_set[c]   = len_hit[c] && !btt_zero && cmd_full[c] && !cmd_pop[c];
            zbtt_set[c]  = len_hit[c] && btt_zero;

            sts_full[c]     = (sts_cnt[c] == SCW'(STS_DEPTH));
            sts_nonempty[c] = (sts_cnt[c] != '0);
            sts_ready[c]    = !sts_full[c] && !rst;
            sts_push[c]     = S_AXIS_STS_TVALID[c] && sts_ready[c];
            sts_pop[c]      = get_stb && rd_hit && (int'(rd_ch) == c) &&
                              (rd_reg == REG_STS) && sts_nonempty[c];

            cmd_word[c] = {4'h0, tag[c], addr_reg[c], 1'b0, set_data[30], 6'h00,
                           1'b1, set_data[22:0]};
            cmd_tdata[72*c +: 72] = cmd_mem[c][cmd_rp[c]];
        end
    end

    assign M_AXIS_CMD_TVALID = cmd_valid;
    assign M_AXIS_CMD_TDATA  = cmd_tdata;
    assign S_AXIS_STS_TREADY = sts_ready;
    assign irq_vec           = irq_vec_r;
    assign irq               = irq_r;

    // FIFO storage carries no reset; only pointers and counts define contents.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (cmd_push[c]) begin
                cmd_mem[c][cmd_wp[c]] <= cmd_word[c];
            end
            if (sts_push[c]) begin
                sts_mem[c][sts_wp[c]] <= S_AXIS_STS_TDATA[8*c +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                addr_reg[c] <= '0;
                tag[c]      <= '0;
                cmd_wp[c]   <= '0;
                cmd_rp[c]   <= '0;
                cmd_cnt[c]  <= '0;
                sts_wp[c]   <= '0;
                sts_rp[c]   <= '0;
                sts_cnt[c]  <= '0;
            end
            mask_reg  <= '0;
            ovf_flag  <= '0;
            zbtt_flag <= '0;
            irq_vec_r <= '0;
            irq_r     <= 1'b0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (addr_hit[c]) begin
                    addr_reg[c] <= set_data[31:0];
                end
                if (mask_hit[c]) begin
                    mask_reg[c] <= set_data[0];
                end
                if (cmd_push[c]) begin
                    cmd_wp[c] <= cmd_wp[c] + CPW'(1);
                    tag[c]    <= tag[c] + 4'd1;
                end
                if (cmd_pop[c]) begin
                    cmd_rp[c] <= cmd_rp[c] + CPW'(1);
                end
                cmd_cnt[c] <= cmd_cnt[c] + CCW'(cmd_push[c]) - CCW'(cmd_pop[c]);

                if (sts_push[c]) begin
                    sts_wp[c] <= sts_wp[c] + SPW'(1);
                end
                if (sts_pop[c]) begin
                    sts_rp[c] <= sts_rp[c] + SPW'(1);
                end
                sts_cnt[c] <= sts_cnt[c] + SCW'(sts_push[c]) - SCW'(sts_pop[c]);

                // Setting a sticky wins over a W1C clear in the same cycle.
                ovf_flag[c]  <= ovf_set[c] | (ovf_flag[c] & ~(cnt_hit[c] & set_data[31]));
                zbtt_flag[c] <= zbtt_set[c] | (zbtt_flag[c] & ~(cnt_hit[c] & set_data[30]));
            end
            irq_vec_r <= mask_reg & sts_nonempty;
            irq_r     <= |(mask_reg & sts_nonempty);
        end
    end

    // Register read mux
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (rd_hit) begin
            case (rd_reg)
                REG_ADDR: rd_val = addr_reg[rd_ch];
                REG_STS: begin
                    if (sts_nonempty[rd_ch]) begin
                        rd_val = {1'b1, 23'h0, sts_mem[rd_ch][sts_rp[rd_ch]]};
                    end
                end
                REG_CNT:  rd_val = {ovf_flag[rd_ch], zbtt_flag[rd_ch], 10'h0, tag[rd_ch],
                                    8'(sts_cnt[rd_ch]), 8'(cmd_cnt[rd_ch])};
                REG_MASK: rd_val = {31'h0, mask_reg[rd_ch]};
                default:  rd_val = '0;
            endcase
        end
    end

    assign get_data = rd_val;

endmodule
